// File: rtl/echo_pkg.sv
// echo_pkg: shared types and default widths for the echo client.
//   state_t   : client FSM state encoding (IDLE, RUN, DRAIN, DONE)
//   W_DEF     : default payload width
//   CW_DEF    : default request/statistics counter width
//   DEPTH_DEF : default number of outstanding requests tracked
package echo_pkg;

  localparam int W_DEF     = 32;
  localparam int CW_DEF    = 16;
  localparam int DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/echo_client_fifo.sv
// echo_client_fifo: synchronous DEPTH x W FIFO holding the values that
// have been sent but not yet heard back.
//   CLK, nRST  : clock, synchronous active-high reset (empties the FIFO)
//   push       : write push_data (ignored when full)
//   push_data  : value to store
//   pop        : drop the head entry (ignored when empty)
//   head       : oldest stored value
//   empty/full : derived from the registered occupancy
//   count      : registered occupancy, 0..DEPTH
// Push and pop in the same cycle are both honoured; occupancy is unchanged.
module echo_client_fifo
  import echo_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int W     = W_DEF,
  localparam int AW   = $clog2(DEPTH),
  localparam int CNTW = AW + 1
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            push,
  input  logic [W-1:0]    push_data,
  input  logic            pop,
  output logic [W-1:0]    head,
  output logic            empty,
  output logic            full,
  output logic [CNTW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_en;
  logic          rd_en;

  assign empty = (count == '0);
  assign full  = (count == CNTW'(DEPTH));
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign head  = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge CLK) begin
    if (nRST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNTW'(wr_en) - CNTW'(rd_en);
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/echo_client.sv
// echo_client: initiator side of the say/heard echo protocol. Issues a
// numbered stream of say(v) requests starting at start_seed, remembers
// each one in a tracking FIFO, and checks returning heard(v) indications
// against it in order.
//   CLK, nRST                      : clock, synchronous active-high reset
//   start__ENA/_count/_seed/__RDY  : run launch handshake
//   say__ENA, say_v, say__RDY      : outgoing requests
//   heard__ENA, heard_v, heard__RDY: returning indications
//   done                           : run complete (all sent and heard)
//   mismatch, unexpected           : sticky error flags
//   err_count, sent_count, rcvd_count : per-run statistics
//
// state | meaning
// IDLE  | waiting for start after reset
// RUN   | issuing requests, checking indications
// DRAIN | all requests issued, waiting for the remaining indications
// DONE  | run complete; start may launch a new run
module echo_client
  import echo_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CW    = CW_DEF
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          start__ENA,
  input  logic [CW-1:0] start_count,
  input  logic [W-1:0]  start_seed,
  output logic          start__RDY,
  output logic          say__ENA,
  output logic [W-1:0]  say_v,
  input  logic          say__RDY,
  input  logic          heard__ENA,
  input  logic [W-1:0]  heard_v,
  output logic          heard__RDY,
  output logic          done,
  output logic          mismatch,
  output logic          unexpected,
  output logic [CW-1:0] err_count,
  output logic [CW-1:0] sent_count,
  output logic [CW-1:0] rcvd_count
);

  localparam int CNTW = $clog2(DEPTH) + 1;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   target;
  logic [W-1:0]    next_v;

  logic            start_go;
  logic            issue;
  logic            accept;
  logic            stray;
  logic            differ;
  logic [W-1:0]    fifo_head;
  logic            fifo_empty;
  logic            fifo_full;
  logic [CNTW-1:0] fifo_count;
  logic [CNTW-1:0] count_after;
  logic [CW-1:0]   sent_after;

  echo_client_fifo #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_fifo (
    .CLK       (CLK),
    .nRST      (nRST),
    .push      (issue),
    .push_data (next_v),
    .pop       (accept),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  assign start__RDY = (state == IDLE) || (state == DONE);
  assign done       = (state == DONE);
  assign start_go   = start__ENA && start__RDY;

  // Full comes from registered occupancy: a pop this cycle does not free
  // a slot for an issue in the same cycle.
  assign issue      = (state == RUN) && (sent_count < target) && !fifo_full && say__RDY;
  assign say__ENA   = issue;
  assign say_v      = next_v;

  assign heard__RDY = ((state == RUN) || (state == DRAIN)) && !fifo_empty;
  assign accept     = heard__ENA && heard__RDY;
  assign stray      = heard__ENA && !heard__RDY;
  assign differ     = accept && (heard_v != fifo_head);

  // Occupancy and sent count as they will be after this edge.
  assign count_after = fifo_count + CNTW'(issue) - CNTW'(accept);
  assign sent_after  = sent_count + CW'(issue);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start_go) state_nxt = (start_count == '0) ? DONE : RUN;
      end
      RUN: begin
        // Last issue coinciding with the last pop finishes in one edge.
        if (sent_after == target) state_nxt = (count_after == '0) ? DONE : DRAIN;
      end
      DRAIN: begin
        if (count_after == '0) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (nRST) begin
      state      <= IDLE;
      target     <= '0;
      next_v     <= '0;
      sent_count <= '0;
      rcvd_count <= '0;
      err_count  <= '0;
      mismatch   <= 1'b0;
      unexpected <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start_go) begin
        target     <= start_count;
        next_v     <= start_seed;
        sent_count <= '0;
        rcvd_count <= '0;
        err_count  <= '0;
        mismatch   <= 1'b0;
        unexpected <= 1'b0;
      end else begin
        if (issue) begin
          next_v     <= next_v + 1'b1;
          sent_count <= sent_after;
        end
        if (accept) rcvd_count <= rcvd_count + 1'b1;
        if (differ) begin
          mismatch <= 1'b1;
          if (err_count != '1) err_count <= err_count + 1'b1;
        end
      end
      if (stray) unexpected <= 1'b1;
    end
  end

endmodule
